// File: rtl/pipe_ctrl.sv
// Stall/flush controller for the 5-stage F/D/E/M/W core, with a stale-fetch tracker and saturating perf counters.
// Latency: pipeline enables, flushes and redirect are combinational from the inputs and state (0 cycles); counters update on the next edge.
// Backpressure: cache waits and mul/div freeze the relevant stages, and those freezes take priority over branch redirects.
module pipe_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_busy,
  input  logic             d_busy,
  input  logic             muldiv_busy,
  input  logic             load_use,
  input  logic             br_mispred,
  input  logic             exc_valid,
  output logic             en_fd,
  output logic             en_de,
  output logic             en_em,
  output logic             en_mw,
  output logic             flush_fd,
  output logic             flush_de,
  output logic             flush_em,
  output logic             flush_mw,
  output logic             redirect,
  output logic             redirect_exc,
  output logic             fetch_discard,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t state, state_nxt;

  // Set once a mispredicted branch has redirected.
  // Later cycles with the same branch still held must not pulse redirect again.
  logic br_seen, br_seen_nxt;
  logic br_row;
  logic f_busy;

  // While draining, F behaves as if the fetch were still outstanding.
  assign f_busy = i_busy | (state == DRAIN);

  // Priority arbitration of pipeline enables/flushes and the redirect pulse
  always_comb begin
    en_fd        = 1'b1;
    en_de        = 1'b1;
    en_em        = 1'b1;
    en_mw        = 1'b1;
    flush_fd     = 1'b0;
    flush_de     = 1'b0;
    flush_em     = 1'b0;
    flush_mw     = 1'b0;
    redirect     = 1'b0;
    redirect_exc = 1'b0;
    br_row       = 1'b0;
    if (reset) begin
      en_fd    = 1'b0;
      en_de    = 1'b0;
      en_em    = 1'b0;
      en_mw    = 1'b0;
      flush_fd = 1'b1;
      flush_de = 1'b1;
      flush_em = 1'b1;
      flush_mw = 1'b1;
    end else if (exc_valid) begin
      flush_fd     = 1'b1;
      flush_de     = 1'b1;
      flush_em     = 1'b1;
      flush_mw     = 1'b1;
      redirect     = 1'b1;
      redirect_exc = 1'b1;
    end else if (d_busy) begin
      en_fd = 1'b0;
      en_de = 1'b0;
      en_em = 1'b0;
      en_mw = 1'b0;
    end else if (muldiv_busy) begin
      en_fd    = 1'b0;
      en_de    = 1'b0;
      en_em    = 1'b0;
      flush_em = 1'b1;
    end else if (br_mispred) begin
      // The delay slot in D is kept; only the instruction in F is killed.
      br_row   = 1'b1;
      flush_fd = 1'b1;
      redirect = !br_seen;
    end else if (load_use) begin
      en_fd    = 1'b0;
      en_de    = 1'b0;
      flush_de = 1'b1;
    end else if (f_busy) begin
      flush_fd = 1'b1;
    end
  end

  // Stale-fetch tracking: next state, discard flag and branch-seen bookkeeping
  always_comb begin
    state_nxt     = state;
    fetch_discard = (state == DRAIN) && !reset;
    br_seen_nxt   = br_mispred && !exc_valid && (br_seen || br_row);
    case (state)
      RUN:     if (redirect && i_busy) state_nxt = DRAIN;
      // Only one response can be outstanding, so a redirect here changes nothing.
      DRAIN:   if (!i_busy) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // State register and saturating performance counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      br_seen   <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state   <= state_nxt;
      br_seen <= br_seen_nxt;
      if (!en_fd && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (redirect && (flush_cnt != {CNT_W{1'b1}}))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule
